// File: rtl/mef_ciclo_lavagem.sv
`default_nettype none
// ============================================================================
// Module      : mef_ciclo_lavagem
// Description : Moore FSM that sequences a washing-machine program.
//               Phases are FILL, WASH, RINSE, SPIN, DRY and DONE, each timed
//               in prescaled ticks. Opening the door pauses the cycle and
//               keeps the timer state. Abort cancels the cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mef_ciclo_lavagem #(
    parameter int TICK_DIV     = 50000000,
    parameter int T_FILL       = 8,
    parameter int T_WASH_ECO   = 10,
    parameter int T_WASH_NORM  = 20,
    parameter int T_WASH_HEAVY = 30,
    parameter int T_RINSE      = 10,
    parameter int T_SPIN       = 6,
    parameter int T_DRY        = 15,
    parameter int T_DONE       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] mode_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       door_closed_i,
    output logic [2:0] phase_o,
    output logic       valve_o,
    output logic       motor_o,
    output logic       pump_o,
    output logic       heater_o,
    output logic       buzz_o,
    output logic [7:0] remaining_o,
    output logic       busy_o
);

    // Phase encoding, also visible on phase_o
    localparam logic [2:0] c_IDLE  = 3'b000;
    localparam logic [2:0] c_FILL  = 3'b001;
    localparam logic [2:0] c_WASH  = 3'b010;
    localparam logic [2:0] c_RINSE = 3'b011;
    localparam logic [2:0] c_SPIN  = 3'b100;
    localparam logic [2:0] c_DRY   = 3'b101;
    localparam logic [2:0] c_DONE  = 3'b110;
    localparam logic [2:0] c_PAUSE = 3'b111;

    // Program codes coming from the selector stage
    localparam logic [2:0] c_PROG_DRY   = 3'b001;
    localparam logic [2:0] c_PROG_ECO   = 3'b010;
    localparam logic [2:0] c_PROG_NORM  = 3'b011;
    localparam logic [2:0] c_PROG_HEAVY = 3'b100;

    // Prescaler width; TICK_DIV=1 still needs a 1-bit counter that is always at max
    localparam int             c_PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(TICK_DIV - 1);

    logic [2:0]      phase_q, phase_d;
    logic [2:0]      saved_q, saved_d;
    logic [2:0]      prog_q,  prog_d;
    logic [7:0]      rem_q,   rem_d;
    logic [c_PW-1:0] presc_q, presc_d;

    logic            w_tick;
    logic            w_mode_ok;
    logic [2:0]      w_first;
    logic [2:0]      w_next;

    // First phase of a program: the drying program goes straight to DRY
    function automatic logic [2:0] f_first(input logic [2:0] prog);
        return (prog == c_PROG_DRY) ? c_DRY : c_FILL;
    endfunction

    // Phase that follows ph in program prog; DONE leads back to IDLE
    function automatic logic [2:0] f_next(input logic [2:0] prog, input logic [2:0] ph);
        logic [2:0] nxt;
        case (ph)
            c_FILL:  nxt = c_WASH;
            c_WASH:  nxt = (prog == c_PROG_ECO) ? c_SPIN : c_RINSE;
            c_RINSE: nxt = c_SPIN;
            c_SPIN:  nxt = (prog == c_PROG_HEAVY) ? c_DRY : c_DONE;
            c_DRY:   nxt = c_DONE;
            default: nxt = c_IDLE;
        endcase
        return nxt;
    endfunction

    // Duration in ticks of phase ph; WASH length depends on the program
    function automatic logic [7:0] f_dur(input logic [2:0] prog, input logic [2:0] ph);
        logic [7:0] d;
        case (ph)
            c_FILL:  d = 8'(T_FILL);
            c_WASH: begin
                case (prog)
                    c_PROG_ECO:   d = 8'(T_WASH_ECO);
                    c_PROG_HEAVY: d = 8'(T_WASH_HEAVY);
                    default:      d = 8'(T_WASH_NORM);
                endcase
            end
            c_RINSE: d = 8'(T_RINSE);
            c_SPIN:  d = 8'(T_SPIN);
            c_DRY:   d = 8'(T_DRY);
            c_DONE:  d = 8'(T_DONE);
            default: d = 8'd0;
        endcase
        return d;
    endfunction

    assign w_tick    = (presc_q == c_PRESC_MAX);
    assign w_mode_ok = (mode_i == c_PROG_DRY) || (mode_i == c_PROG_ECO) ||
                       (mode_i == c_PROG_NORM) || (mode_i == c_PROG_HEAVY);
    assign w_first   = f_first(mode_i);
    assign w_next    = f_next(prog_q, phase_q);

    // Next-state logic; branch order encodes abort > door open > timer expiry
    always_comb begin
        phase_d = phase_q;
        saved_d = saved_q;
        prog_d  = prog_q;
        rem_d   = rem_q;
        presc_d = presc_q;
        if (phase_q == c_IDLE) begin
            rem_d   = 8'd0;
            presc_d = '0;
            if (start_i && !abort_i && door_closed_i && w_mode_ok) begin
                prog_d  = mode_i;
                phase_d = w_first;
                rem_d   = f_dur(mode_i, w_first);
            end
        end else if (abort_i) begin
            phase_d = c_IDLE;
            prog_d  = c_IDLE;
            rem_d   = 8'd0;
            presc_d = '0;
        end else if (phase_q == c_PAUSE) begin
            // Timer frozen; resume the interrupted phase once the door latches
            if (door_closed_i) begin
                phase_d = saved_q;
            end
        end else if (!door_closed_i && (phase_q != c_DONE)) begin
            // Door wins over a coinciding tick: nothing advances, count is kept
            saved_d = phase_q;
            phase_d = c_PAUSE;
        end else if (w_tick) begin
            presc_d = '0;
            if (rem_q <= 8'd1) begin
                phase_d = w_next;
                rem_d   = f_dur(prog_q, w_next);
                if (w_next == c_IDLE) begin
                    prog_d = c_IDLE;
                end
            end else begin
                rem_d = rem_q - 8'd1;
            end
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= c_IDLE;
            saved_q <= c_IDLE;
            prog_q  <= c_IDLE;
            rem_q   <= 8'd0;
            presc_q <= '0;
        end else begin
            phase_q <= phase_d;
            saved_q <= saved_d;
            prog_q  <= prog_d;
            rem_q   <= rem_d;
            presc_q <= presc_d;
        end
    end

    // Moore outputs decoded from registered state only
    assign phase_o     = phase_q;
    assign remaining_o = rem_q;
    assign busy_o      = (phase_q != c_IDLE);
    assign valve_o     = (phase_q == c_FILL) || (phase_q == c_RINSE);
    assign motor_o     = (phase_q == c_WASH) || (phase_q == c_RINSE) || (phase_q == c_SPIN);
    assign pump_o      = (phase_q == c_SPIN);
    assign heater_o    = (phase_q == c_DRY);
    assign buzz_o      = (phase_q == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mef_ciclo_lavagem.sv
`default_nettype none
// ============================================================================
// Module      : tb_mef_ciclo_lavagem
// Description : Directed testbench for mef_ciclo_lavagem. A vector table
//               covers reset, full programs and ignored starts; hand-written
//               sequences cover pause/resume, mode change, abort and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mef_ciclo_lavagem;

    localparam int c_IDLE  = 0;
    localparam int c_FILL  = 1;
    localparam int c_WASH  = 2;
    localparam int c_RINSE = 3;
    localparam int c_SPIN  = 4;
    localparam int c_DRY   = 5;
    localparam int c_DONE  = 6;
    localparam int c_PAUSE = 7;

    // Actuator pattern {valve, motor, pump, heater, buzz}
    localparam int A_OFF   = 5'b00000;
    localparam int A_FILL  = 5'b10000;
    localparam int A_WASH  = 5'b01000;
    localparam int A_RINSE = 5'b11000;
    localparam int A_SPIN  = 5'b01100;
    localparam int A_DRY   = 5'b00010;
    localparam int A_DONE  = 5'b00001;

    logic       clk;
    logic       rst;
    logic [2:0] mode_i;
    logic       start_i;
    logic       abort_i;
    logic       door_closed_i;
    logic [2:0] phase_o;
    logic       valve_o, motor_o, pump_o, heater_o, buzz_o;
    logic [7:0] remaining_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;
    bit saw_dry = 0;

    mef_ciclo_lavagem #(
        .TICK_DIV    (2),
        .T_FILL      (2),
        .T_WASH_ECO  (3),
        .T_WASH_NORM (2),
        .T_WASH_HEAVY(2),
        .T_RINSE     (2),
        .T_SPIN      (1),
        .T_DRY       (2),
        .T_DONE      (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode_i       (mode_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .door_closed_i(door_closed_i),
        .phase_o      (phase_o),
        .valve_o      (valve_o),
        .motor_o      (motor_o),
        .pump_o       (pump_o),
        .heater_o     (heater_o),
        .buzz_o       (buzz_o),
        .remaining_o  (remaining_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] mode;
        logic       start;
        logic       abort;
        logic       door;
        int         ph;
        int         rem;
        int         act;
        int         busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int r, input int m, input int s, input int a, input int d,
                                input int ph, input int rem, input int act, input int busy);
        vec_t v;
        v.rst   = 1'(r);
        v.mode  = 3'(m);
        v.start = 1'(s);
        v.abort = 1'(a);
        v.door  = 1'(d);
        v.ph    = ph;
        v.rem   = rem;
        v.act   = act;
        v.busy  = busy;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (phase_o == 3'd5) saw_dry = 1'b1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input int ph, input int rem, input int act, input int busy);
        chk({tag, " phase"},     int'(phase_o), ph);
        chk({tag, " remaining"}, int'(remaining_o), rem);
        chk({tag, " actuators"}, int'({valve_o, motor_o, pump_o, heater_o, buzz_o}), act);
        chk({tag, " busy"},      int'(busy_o), busy);
    endtask

    task automatic drive(input int r, input int m, input int s, input int a, input int d);
        rst           = 1'(r);
        mode_i        = 3'(m);
        start_i       = 1'(s);
        abort_i       = 1'(a);
        door_closed_i = 1'(d);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 1);
        step();
        rst = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 1);

        // Reset, economy run, ignored starts, drying run with a start while busy
        vecs.push_back(mk(0, 0, 0, 0, 1, c_IDLE, 0, A_OFF, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, c_IDLE, 0, A_OFF, 0));
        vecs.push_back(mk(1, 2, 1, 0, 1, c_FILL, 2, A_FILL, 1));
        vecs.push_back(mk(1, 2, 0, 0, 1, c_FILL, 2, A_FILL, 1));
        vecs.push_back(mk(1, 2, 0, 0, 1, c_FILL, 1, A_FILL, 1));
        vecs.push_back(mk(1, 2, 0, 0, 1, c_FILL, 1, A_FILL, 1));
        vecs.push_back(mk(1, 2, 0, 0, 1, c_WASH, 3, A_WASH, 1));
        vecs.push_back(mk(1, 2, 0, 0, 1, c_WASH, 3, A_WASH, 1));
        vecs.push_back(mk(1, 2, 0, 0, 1, c_WASH, 2, A_WASH, 1));
        vecs.push_back(mk(1, 2, 0, 0, 1, c_WASH, 2, A_WASH, 1));
        vecs.push_back(mk(1, 2, 0, 0, 1, c_WASH, 1, A_WASH, 1));
        vecs.push_back(mk(1, 2, 0, 0, 1, c_WASH, 1, A_WASH, 1));
        vecs.push_back(mk(1, 2, 0, 0, 1, c_SPIN, 1, A_SPIN, 1));
        vecs.push_back(mk(1, 2, 0, 0, 1, c_SPIN, 1, A_SPIN, 1));
        vecs.push_back(mk(1, 2, 0, 0, 1, c_DONE, 1, A_DONE, 1));
        vecs.push_back(mk(1, 2, 0, 0, 1, c_DONE, 1, A_DONE, 1));
        vecs.push_back(mk(1, 2, 0, 0, 1, c_IDLE, 0, A_OFF, 0));
        vecs.push_back(mk(1, 5, 1, 0, 1, c_IDLE, 0, A_OFF, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, c_IDLE, 0, A_OFF, 0));
        vecs.push_back(mk(1, 3, 1, 0, 0, c_IDLE, 0, A_OFF, 0));
        vecs.push_back(mk(1, 3, 0, 0, 1, c_IDLE, 0, A_OFF, 0));
        vecs.push_back(mk(1, 6, 1, 0, 1, c_IDLE, 0, A_OFF, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1, c_IDLE, 0, A_OFF, 0));
        vecs.push_back(mk(1, 1, 1, 0, 1, c_DRY, 2, A_DRY, 1));
        vecs.push_back(mk(1, 2, 1, 0, 1, c_DRY, 2, A_DRY, 1));
        vecs.push_back(mk(1, 2, 0, 0, 1, c_DRY, 1, A_DRY, 1));
        vecs.push_back(mk(1, 2, 0, 0, 1, c_DRY, 1, A_DRY, 1));
        vecs.push_back(mk(1, 2, 0, 0, 1, c_DONE, 1, A_DONE, 1));
        vecs.push_back(mk(1, 2, 0, 0, 1, c_DONE, 1, A_DONE, 1));
        vecs.push_back(mk(1, 2, 0, 0, 1, c_IDLE, 0, A_OFF, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].mode, vecs[i].start, vecs[i].abort, vecs[i].door);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].ph, vecs[i].rem, vecs[i].act, vecs[i].busy);
        end

        // Heavy run: door opens at WASH entry, pause 10 cycles, resume, then abort in RINSE
        do_reset();
        drive(1, 4, 1, 0, 1);
        step();
        start_i = 1'b0;
        chk_out("heavy fill", c_FILL, 2, A_FILL, 1);
        for (int i = 0; i < 4; i++) step();
        chk_out("heavy wash entry", c_WASH, 2, A_WASH, 1);
        door_closed_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_out($sformatf("pause%0d", i), c_PAUSE, 2, A_OFF, 1);
        end
        door_closed_i = 1'b1;
        step();
        chk_out("wash resume", c_WASH, 2, A_WASH, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk({"wash resumed phase ", $sformatf("%0d", i)}, int'(phase_o), c_WASH);
        end
        step();
        chk_out("heavy rinse", c_RINSE, 2, A_RINSE, 1);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk_out("abort in rinse", c_IDLE, 0, A_OFF, 0);

        // Normal run with mode switched to drying mid-wash: DRY must never appear
        do_reset();
        saw_dry = 1'b0;
        drive(1, 3, 1, 0, 1);
        step();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk_out("norm wash", c_WASH, 2, A_WASH, 1);
        mode_i  = 3'b001;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk_out("norm wash hold", c_WASH, 2, A_WASH, 1);
        for (int i = 0; i < 3; i++) step();
        chk_out("norm rinse", c_RINSE, 2, A_RINSE, 1);
        for (int i = 0; i < 4; i++) step();
        chk_out("norm spin", c_SPIN, 1, A_SPIN, 1);
        for (int i = 0; i < 2; i++) step();
        chk_out("norm done", c_DONE, 1, A_DONE, 1);
        for (int i = 0; i < 2; i++) step();
        chk_out("norm idle", c_IDLE, 0, A_OFF, 0);
        chk("norm dry seen", int'(saw_dry), 0);

        // Economy run, reset asserted in SPIN
        do_reset();
        drive(1, 2, 1, 0, 1);
        step();
        start_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk_out("eco spin", c_SPIN, 1, A_SPIN, 1);
        rst = 1'b0;
        step();
        chk_out("rst in spin", c_IDLE, 0, A_OFF, 0);
        rst = 1'b1;

        // Reset from PAUSE: the saved phase must not come back
        drive(1, 2, 1, 0, 1);
        step();
        start_i       = 1'b0;
        door_closed_i = 1'b0;
        step();
        chk_out("pause before rst", c_PAUSE, 2, A_OFF, 1);
        rst = 1'b0;
        step();
        chk_out("rst in pause", c_IDLE, 0, A_OFF, 0);
        rst           = 1'b1;
        door_closed_i = 1'b1;
        step();
        chk_out("idle after rst", c_IDLE, 0, A_OFF, 0);

        // Door opens on the final tick of FILL; prescaler state must survive the pause
        do_reset();
        drive(1, 2, 1, 0, 1);
        step();
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk_out("fill last", c_FILL, 1, A_FILL, 1);
        door_closed_i = 1'b0;
        step();
        chk_out("final tick pause", c_PAUSE, 1, A_OFF, 1);
        step();
        door_closed_i = 1'b1;
        step();
        chk_out("fill resume", c_FILL, 1, A_FILL, 1);
        step();
        chk_out("wash after resume", c_WASH, 3, A_WASH, 1);

        // Abort from PAUSE
        door_closed_i = 1'b0;
        step();
        chk_out("pause in wash", c_PAUSE, 3, A_OFF, 1);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk_out("abort in pause", c_IDLE, 0, A_OFF, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mef_ciclo_lavagem.md
MEF_CICLO_LAVAGEM -- requirements
Module: mef_ciclo_lavagem

Interface
REQ-001 Parameter TICK_DIV, default 50000000: clk cycles per timer tick; legal range 1 or more.
REQ-002 Parameter T_FILL, default 8: FILL duration in ticks; legal range 1..255. The same range applies to every T_* parameter.
REQ-003 Parameters T_WASH_ECO, T_WASH_NORM and T_WASH_HEAVY, defaults 10, 20 and 30: WASH duration per mode, in ticks.
REQ-004 Parameters T_RINSE, T_SPIN, T_DRY and T_DONE, defaults 10, 6, 15 and 3: phase durations in ticks.
REQ-005 clk  input  1  clock; all state changes on posedge.
REQ-006 rst  input  1  reset; synchronous, active-low.
REQ-007 mode  input  3  program code from the selector stage: 000 menu, 001 secagem, 010 economica, 011 normal, 100 pesada, 101/110 error codes.
REQ-008 start  input  1  single-cycle request to run the program given on mode.
REQ-009 abort  input  1  level; cancels the cycle.
REQ-010 door_closed  input  1  level; 1 = door latched.
REQ-011 phase  output  3  current state: IDLE 000, FILL 001, WASH 010, RINSE 011, SPIN 100, DRY 101, DONE 110, PAUSE 111.
REQ-012 valve, motor, pump, heater, buzz  output  1 each  actuator enables.
REQ-013 remaining  output  8  ticks left in the current phase; 0 in IDLE.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL be a Moore FSM, and every output SHALL be a function of registered state only.
REQ-016 In IDLE, a start with door_closed=1 and mode in {001,010,011,100} SHALL latch mode into prog and enter the first phase of that program on the next edge.
- In IDLE, start with any other mode code, or with door_closed=0, SHALL be ignored.
REQ-017 Program sequences, each ending with DONE:
- 001: DRY.
- 010: FILL, WASH(T_WASH_ECO), SPIN.
- 011: FILL, WASH(T_WASH_NORM), RINSE, SPIN.
- 100: FILL, WASH(T_WASH_HEAVY), RINSE, SPIN, DRY.
REQ-018 Changes on mode, and start pulses, while busy=1 SHALL be ignored; prog is fixed until the block returns to IDLE.
REQ-019 Tick generation:
- A prescaler SHALL count 0..TICK_DIV-1 and raise tick when it wraps.
- The prescaler SHALL clear on every phase entry and SHALL hold while in PAUSE.
REQ-020 Phase timing:
- On phase entry, remaining SHALL load that phase's T value.
- remaining SHALL decrement by 1 on each tick.
- A tick with remaining=1 SHALL advance to the next phase.
- Each phase therefore lasts exactly T×TICK_DIV cycles.
REQ-021 DONE SHALL last T_DONE ticks and then enter IDLE with remaining=0.
REQ-022 Actuator decode:
- valve=1 in FILL and RINSE.
- motor=1 in WASH, RINSE and SPIN.
- pump=1 in SPIN.
- heater=1 in DRY.
- buzz=1 in DONE.
- All actuators SHALL be 0 in IDLE and PAUSE.
REQ-023 door_closed=0 in any of FILL..DRY SHALL enter PAUSE on the next edge.
- The interrupted phase, remaining and the prescaler count SHALL be preserved.
- When door_closed returns to 1, the block SHALL resume the saved phase with the same remaining value.
- door_closed is not checked in DONE.
REQ-024 Priority on the same edge: rst, then abort, then door open, then timer expiry.
- abort=1 in any non-IDLE state SHALL enter IDLE on the next edge and zero remaining.
REQ-025 A tick with remaining=1 in the same cycle that the door opens SHALL enter PAUSE without advancing the phase.

Reset
REQ-026 While rst=0 at a clock edge, the block SHALL force all of the following, including mid-cycle and from PAUSE:
- phase=000, remaining=0, busy=0.
- All actuators 0.
- prescaler=0 and prog=000.

Verification (TICK_DIV=2, T_FILL=2, T_WASH_ECO=3, T_SPIN=1, T_DONE=1, other T_*=2)
REQ-027 mode=010, start pulse, door closed -> expected sequence:
- phase goes FILL (4 cycles, valve=1), WASH (6 cycles, motor=1), SPIN (2 cycles, motor=1, pump=1), DONE (2 cycles, buzz=1), then IDLE, busy=0.
REQ-028 Ignored starts:
- mode=101, start pulse -> phase stays 000.
- mode=011, start with door_closed=0 -> phase stays 000.
REQ-029 mode=100 run, door opens in WASH with remaining=2:
- phase=111, all actuators 0, remaining holds 2 for 10 cycles.
- After the door closes, WASH resumes and completes after 4 more cycles.
REQ-030 mode=011 run; mode switched to 001 during WASH -> sequence continues RINSE then SPIN, and DRY is never entered.
REQ-031 Cancel mid-run:
- abort pulse during RINSE -> IDLE on the next edge, remaining=0.
- rst=0 during SPIN -> all outputs 0 after one edge.
REQ-032 door opening on the same cycle as a final tick -> PAUSE; after the door closes, the same phase resumes with remaining=1.
